byte_deserializer: RTL and testbench
====================================

BYTE_DESERIALIZER -- requirements
Module: byte_deserializer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of bits per word; the legal range is 2..16.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the reset, synchronous and active-high.
REQ-004 Port bit_in, input, 1 bit, SHALL carry serial data, MSB first.
REQ-005 Port bit_valid, input, 1 bit, SHALL qualify bit_in; bit_in is sampled only when bit_valid=1.
REQ-006 Port sync, input, 1 bit, SHALL be a word-alignment strobe that discards any partial word.
REQ-007 Port out_data, output, WIDTH bits, SHALL present the assembled word.
REQ-008 Port out_valid, output, 1 bit, SHALL be high while out_data holds an unconsumed word.
REQ-009 Port out_ready, input, 1 bit, SHALL signal consumer acceptance; a transfer occurs when out_valid=1 and out_ready=1.
REQ-010 Port busy, output, 1 bit, SHALL be high while the partial-word bit count is nonzero.
REQ-011 Port overrun, output, 1 bit, SHALL be a sticky error flag.

Function
REQ-012 Shift path: each edge with bit_valid=1 SHALL perform shift_reg <= {shift_reg[WIDTH-2:0], bit_in} and increment bit_cnt.
REQ-013 Word completion: on the edge that samples bit number WIDTH, the word SHALL be complete, and bit_cnt SHALL wrap to 0 in that same edge.
REQ-014 Output load: on completion, if the holding register is empty or is being transferred in that cycle, the block SHALL load out_data = {shift_reg[WIDTH-2:0], bit_in} and set out_valid=1 on that same edge (zero added latency).
REQ-015 Holding: out_valid SHALL stay high and out_data SHALL stay stable until a transfer occurs.
REQ-016 Clearing: a transfer with no simultaneous completion SHALL clear out_valid on the next edge.
REQ-017 Simultaneous completion and transfer: the new word SHALL load, out_valid SHALL remain 1, and overrun SHALL NOT be set.
REQ-018 Overrun: a completion while out_valid=1 and out_ready=0 SHALL:
- drop the new word;
- leave out_data unchanged;
- set overrun=1.
REQ-019 Clearing overrun: overrun SHALL clear only on reset.
REQ-020 sync=1 with bit_valid=0 SHALL set bit_cnt to 0 and discard the partial word.
REQ-021 sync=1 with bit_valid=1 SHALL treat bit_in as bit 1 of a new word (bit_cnt becomes 1).
REQ-022 sync SHALL NOT affect out_valid, out_data or overrun.
REQ-023 Idle cycles (bit_valid=0, sync=0) SHALL hold all state; gaps between bits are unlimited.
REQ-024 Control SHALL be a two-state machine:
- EMPTY goes to FULL on completion.
- FULL goes to EMPTY on a transfer without completion.
- FULL stays FULL on a transfer with completion, and on completion without a transfer (overrun).
- out_valid SHALL equal (state==FULL).
REQ-025 busy SHALL be combinational: (bit_cnt != 0).

Reset
REQ-026 While rst=1 at a clock edge, the block SHALL set:
- out_data=0, out_valid=0, overrun=0;
- bit_cnt=0, shift_reg=0, state=EMPTY.
REQ-027 Reset SHALL take priority over bit_valid, sync and out_ready; a reset mid-word SHALL discard the partial word and any held word.
REQ-028 Bits presented on the first edge after rst deasserts SHALL be accepted normally.

Structure
REQ-029 The state encoding (EMPTY, FULL) and the default WIDTH constant SHALL live in the shared package used by the block.
REQ-030 bit_cnt width SHALL be $clog2(WIDTH+1).
REQ-031 The block SHALL be a single module with no sub-modules; the shift register, counter and FSM are inline.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Basic word: after reset, with out_ready=1, shift 1,0,1,0,0,1,0,1 on consecutive edges -> out_data=0xA5 and out_valid=1 on the edge of the 8th bit, busy=0 afterward.
- Back-to-back: with out_ready=1, stream 0x3C then 0xC3 continuously -> two transfers of 0x3C then 0xC3, overrun=0.
- Overrun: with out_ready=0, stream 0x11 then 0x22 -> out_data stays 0x11 and overrun=1 after the 16th bit; then raise out_ready -> 0x11 transfers, out_valid=0, overrun remains 1.
- Simultaneous event: hold 0x55 with out_ready=0; raise out_ready on the same edge as the 8th bit of 0xAA -> 0x55 transfers, out_data=0xAA, out_valid=1, overrun=0.
- Sync: shift 3 bits, pulse sync alone, then shift 0xF0 -> out_data=0xF0; repeat with sync coincident with the first bit of 0x0F -> out_data=0x0F.
- Reset mid-word: shift 5 bits with 0x77 held, assert rst -> next edge has out_valid=0, busy=0, out_data=0; a following 0x81 assembles correctly.

Source files
------------

// File: rtl/byte_deserializer_pkg.sv
// ============================================================================
// byte_deserializer_pkg : shared width default and control-state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package byte_deserializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage : byte_deserializer_pkg

`default_nettype wire

// File: rtl/byte_deserializer_if.sv
// ============================================================================
// byte_deserializer_if : serial input, word output handshake and status flags
// Rev 1.0
// ============================================================================
`default_nettype none

interface byte_deserializer_if #(
  parameter int WIDTH = byte_deserializer_pkg::DEFAULT_WIDTH
);

  logic             bit_in;
  logic             bit_valid;
  logic             sync;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic             overrun;

  // Source/sink side: feeds bits and consumes words
  modport master (
    output bit_in, bit_valid, sync, out_ready,
    input  out_data, out_valid, busy, overrun
  );

  // Deserializer side
  modport slave (
    input  bit_in, bit_valid, sync, out_ready,
    output out_data, out_valid, busy, overrun
  );

endinterface : byte_deserializer_if

`default_nettype wire

// File: rtl/byte_deserializer.sv
// ============================================================================
// byte_deserializer : MSB-first serial-to-parallel converter with a one-word
// holding register, valid/ready output and sticky overrun flag. Rev 1.0
// ============================================================================
`default_nettype none

module byte_deserializer
  import byte_deserializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic          clk,
  input  wire logic          rst,
  byte_deserializer_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  // Only the low WIDTH-1 shifted bits ever reach the output; the newest bit
  // comes straight from bit_in on the completing edge.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             overrun_q, overrun_d;

  logic [CW-1:0]    cnt_base;
  logic [WIDTH-2:0] shift_base;
  logic [WIDTH-1:0] word;
  logic             complete;

  always_comb begin
    cnt_base   = bus.sync ? '0 : cnt_q;
    shift_base = bus.sync ? '0 : shift_q;
    word       = {shift_base, bus.bit_in};
    complete   = bus.bit_valid && (cnt_base == CW'(WIDTH - 1));

    shift_d = shift_base;
    cnt_d   = cnt_base;
    if (bus.bit_valid) begin
      shift_d = word[WIDTH-2:0];
      cnt_d   = complete ? '0 : cnt_base + CW'(1);
    end

    state_d   = state_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    case (state_q)
      ST_EMPTY: begin
        if (complete) begin
          state_d = ST_FULL;
          data_d  = word;
        end
      end
      default: begin
        if (complete) begin
          // Stay FULL: either the held word leaves as the new one arrives,
          // or the new word is dropped.
          if (bus.out_ready) data_d    = word;
          else               overrun_d = 1'b1;
        end else if (bus.out_ready) begin
          state_d = ST_EMPTY;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      state_q   <= ST_EMPTY;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.busy      = (cnt_q != '0);
  assign bus.overrun   = overrun_q;

endmodule : byte_deserializer

`default_nettype wire

// File: tb/tb_byte_deserializer.sv
// ============================================================================
// tb_byte_deserializer : directed scenarios, bit-queue reference model checked
// every cycle, plus literal expectations on words and transfers. Rev 1.0
// ============================================================================
`default_nettype none

module tb_byte_deserializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  byte_deserializer_if #(.WIDTH(W)) bus ();

  byte_deserializer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: partial word as a bit queue, holding register as a flag
  bit         part[$];
  logic [7:0] m_data;
  bit         m_full, m_ovr, started;
  logic [7:0] mdl_x[$];
  logic [7:0] dut_x[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit         done;
    logic [7:0] w;
    started = 1'b1;
    done    = 1'b0;
    w       = '0;
    if (!rst && bus.out_valid && bus.out_ready) dut_x.push_back(bus.out_data);
    if (rst) begin
      part.delete();
      m_full = 1'b0;
      m_data = '0;
      m_ovr  = 1'b0;
    end else begin
      if (m_full && bus.out_ready) mdl_x.push_back(m_data);
      if (bus.sync) part.delete();
      if (bus.bit_valid) begin
        part.push_back(bus.bit_in);
        if (part.size() == W) begin
          foreach (part[i]) w = w * 2 + {7'd0, part[i]};
          part.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!m_full || bus.out_ready) begin
          m_data = w;
          m_full = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_full && bus.out_ready) begin
        m_full = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc out_valid", {31'd0, bus.out_valid}, {31'd0, m_full});
      check("cyc out_data",  {24'd0, bus.out_data},  {24'd0, m_data});
      check("cyc busy",      {31'd0, bus.busy},      {31'd0, part.size() != 0});
      check("cyc overrun",   {31'd0, bus.overrun},   {31'd0, m_ovr});
    end
  end

  task automatic step(input logic bv, input logic b, input logic sy, input logic rdy);
    bus.bit_valid = bv;
    bus.bit_in    = b;
    bus.sync      = sy;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy);
    for (int i = 7; i >= 0; i--) step(1'b1, w[i], 1'b0, rdy);
  endtask

  task automatic check_xfers(input string name, input int n, input logic [7:0] e0, input logic [7:0] e1);
    check({name, " dut xfer count"},   dut_x.size(), n);
    check({name, " model xfer count"}, mdl_x.size(), n);
    if (n > 0) begin
      check({name, " dut xfer0"},   dut_x.size() > 0 ? {24'd0, dut_x[0]} : 32'hx, {24'd0, e0});
      check({name, " model xfer0"}, mdl_x.size() > 0 ? {24'd0, mdl_x[0]} : 32'hx, {24'd0, e0});
    end
    if (n > 1) begin
      check({name, " dut xfer1"},   dut_x.size() > 1 ? {24'd0, dut_x[1]} : 32'hx, {24'd0, e1});
      check({name, " model xfer1"}, mdl_x.size() > 1 ? {24'd0, mdl_x[1]} : 32'hx, {24'd0, e1});
    end
    dut_x.delete();
    mdl_x.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    dut_x.delete();
    mdl_x.delete();
  endtask

  initial begin
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.sync      = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset out_data",  {24'd0, bus.out_data},  32'd0);
    check("reset overrun",   {31'd0, bus.overrun},   32'd0);
    check("reset busy",      {31'd0, bus.busy},      32'd0);
    rst = 1'b0;

    // Basic word, first bit on the first edge after reset release
    send_word(8'hA5, 1'b1);
    check("basic out_data",  {24'd0, bus.out_data},  32'hA5);
    check("basic out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("basic busy",      {31'd0, bus.busy},      32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("basic drained", {31'd0, bus.out_valid}, 32'd0);
    check_xfers("basic", 1, 8'hA5, 8'h00);

    // Back-to-back words with a ready consumer
    send_word(8'h3C, 1'b1);
    send_word(8'hC3, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_xfers("b2b", 2, 8'h3C, 8'hC3);
    check("b2b overrun", {31'd0, bus.overrun}, 32'd0);

    // Overrun: second word dropped while the first is held
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    check("ovr out_data",  {24'd0, bus.out_data},  32'h11);
    check("ovr out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("ovr flag",      {31'd0, bus.overrun},   32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("ovr drained",   {31'd0, bus.out_valid}, 32'd0);
    check("ovr sticky",    {31'd0, bus.overrun},   32'd1);
    check_xfers("ovr", 1, 8'h11, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr still sticky", {31'd0, bus.overrun}, 32'd1);

    // Simultaneous completion and transfer
    do_reset();
    send_word(8'h55, 1'b0);
    for (int i = 7; i >= 1; i--) step(1'b1, i[0] ? 1'b1 : 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("sim out_data",  {24'd0, bus.out_data},  32'hAA);
    check("sim out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("sim overrun",   {31'd0, bus.overrun},   32'd0);
    check_xfers("sim", 1, 8'h55, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_xfers("sim drain", 1, 8'hAA, 8'h00);

    // Sync alone discards a partial word
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("sync busy before", {31'd0, bus.busy}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("sync busy after",  {31'd0, bus.busy}, 32'd0);
    send_word(8'hF0, 1'b0);
    check("sync F0", {24'd0, bus.out_data}, 32'hF0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Sync coincident with the first bit of the next word
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 6; i >= 0; i--) step(1'b1, i < 4 ? 1'b1 : 1'b0, 1'b0, 1'b0);
    check("sync 0F",       {24'd0, bus.out_data},  32'h0F);
    check("sync 0F valid", {31'd0, bus.out_valid}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_xfers("sync", 2, 8'hF0, 8'h0F);

    // Reset mid-word with a held word
    send_word(8'h77, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("midrst held", {24'd0, bus.out_data}, 32'h77);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("midrst out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("midrst busy",      {31'd0, bus.busy},      32'd0);
    check("midrst out_data",  {24'd0, bus.out_data},  32'd0);
    rst = 1'b0;
    dut_x.delete();
    mdl_x.delete();
    send_word(8'h81, 1'b0);
    check("midrst 81",       {24'd0, bus.out_data},  32'h81);
    check("midrst 81 valid", {31'd0, bus.out_valid}, 32'd1);
    check("midrst overrun",  {31'd0, bus.overrun},   32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_byte_deserializer

`default_nettype wire
